// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared types and constants for the MIPS fetch queue
package mips_fetch_pkg;

  typedef enum logic [0:0] {
    S_FETCH      = 1'b0,
    S_REDIR_WAIT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  localparam int ENTRY_ADDR_W = 32;
  localparam int ENTRY_INST_W = 32;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] pc;
    logic [ENTRY_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_fifo.sv
// rtl/mips_fetch_fifo.sv - registered sync FIFO with flush, full/empty/count
module mips_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full queue only lands when the head leaves in the same cycle
  assign do_push   = push & (~full | pop);
  assign do_pop    = pop & ~empty;
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  // Pointer and occupancy tracking; flush beats any same-cycle push or pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mips_fetch_queue.sv
// rtl/mips_fetch_queue.sv - IF stage: PC, redirect FSM and fetch queue; MIPS_FETCH_PERF_EN adds perf counters
module mips_fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              I_read,
  output logic [ADDR_W-3:0] I_addr,
  input  logic              I_stall,
  input  logic [INST_W-1:0] I_rdata,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              IF_stall
`ifdef MIPS_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch,
  output logic [31:0]       perf_bubble,
  output logic [31:0]       perf_flush
`endif
);

  localparam int WIDTH = ADDR_W + INST_W;

  fetch_state_e      state, next_state;
  logic [ADDR_W-1:0] pc, pc_next, pc_plus4;
  logic [ADDR_W-1:0] pending, pending_next;
  logic [ADDR_W-1:0] target;
  logic              accept, push, pop, flush;
  logic              full, empty;
  logic [WIDTH-1:0]  head;
  logic [$clog2(DEPTH):0] count;

  assign pc_plus4 = pc + ADDR_W'(4);
  assign target   = redirect_pc & ~ADDR_W'(3);
  assign I_addr   = pc[ADDR_W-1:2];
  assign pop      = ~empty & id_ready;
  assign id_valid = ~empty;
  assign IF_stall = empty;
  assign id_pc    = empty ? '0 : head[WIDTH-1:INST_W];
  assign id_inst  = empty ? INST_W'(NOP_INST) : head[INST_W-1:0];

  mips_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data ({pc_plus4, I_rdata}),
    .pop       (pop),
    .head_data (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Next-state, PC/pending update and cache request; I_read depends on registered full only
  always_comb begin
    next_state   = state;
    pc_next      = pc;
    pending_next = pending;
    push         = 1'b0;
    flush        = 1'b0;
    I_read       = 1'b0;
    if (!rst) I_read = (state == S_REDIR_WAIT) ? 1'b1 : ~full;
    accept = I_read & ~I_stall;
    case (state)
      S_FETCH: begin
        if (redirect) begin
          flush = 1'b1;
          if (I_read && I_stall) begin
            pending_next = target;
            next_state   = S_REDIR_WAIT;
          end else begin
            pc_next = target;
          end
        end else if (accept) begin
          push    = 1'b1;
          pc_next = pc_plus4;
        end
      end
      S_REDIR_WAIT: begin
        if (redirect) flush = 1'b1;
        if (!I_stall) begin
          pc_next    = redirect ? target : pending;
          next_state = S_FETCH;
        end else if (redirect) begin
          pending_next = target;
        end
      end
      default: next_state = S_FETCH;
    endcase
  end

  // State, PC and held redirect target registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      pending <= '0;
    end else begin
      state   <= next_state;
      pc      <= pc_next;
      pending <= pending_next;
    end
  end

`ifdef MIPS_FETCH_PERF_EN
  // Event counters; every redirect counts, including ones absorbed while waiting on a miss
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch  <= '0;
      perf_bubble <= '0;
      perf_flush  <= '0;
    end else begin
      if (accept)               perf_fetch  <= perf_fetch + 32'd1;
      if (id_ready && empty)    perf_bubble <= perf_bubble + 32'd1;
      if (redirect)             perf_flush  <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_fetch_queue.sv
// tb/tb_mips_fetch_queue.sv - scoreboard bench for mips_fetch_queue
module tb_mips_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        I_read;
  logic [29:0] I_addr;
  logic        I_stall = 1'b0;
  logic [31:0] I_rdata;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        IF_stall;
`ifdef MIPS_FETCH_PERF_EN
  logic [31:0] perf_fetch, perf_bubble, perf_flush;
`endif

  always #5 clk = ~clk;

  // Instruction memory image: word address tagged with a nonzero top field
  assign I_rdata = {2'b10, I_addr};

  mips_fetch_queue #(
    .ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .I_read      (I_read),
    .I_addr      (I_addr),
    .I_stall     (I_stall),
    .I_rdata     (I_rdata),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .IF_stall    (IF_stall)
`ifdef MIPS_FETCH_PERF_EN
    ,
    .perf_fetch  (perf_fetch),
    .perf_bubble (perf_bubble),
    .perf_flush  (perf_flush)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic [63:0] sb[$];
  logic [31:0] mpc = '0;
  logic [31:0] mpend = '0;
  logic [31:0] mtgt;
  logic [63:0] ment;
  logic        mwait = 1'b0;
  logic        m_iread;

  // Reference model evaluated mid-cycle, stepped for the coming rising edge
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      mpc   = '0;
      mpend = '0;
      mwait = 1'b0;
      chk("rst_iread",  64'(I_read),   64'(0));
      chk("rst_valid",  64'(id_valid), 64'(0));
      chk("rst_idpc",   64'(id_pc),    64'(0));
      chk("rst_inst",   64'(id_inst),  64'(0));
      chk("rst_ifstall",64'(IF_stall), 64'(1));
    end else begin
      m_iread = mwait ? 1'b1 : (sb.size() < DEPTH);
      mtgt    = {redirect_pc[31:2], 2'b00};
      chk("id_valid", 64'(id_valid), 64'(sb.size() != 0));
      chk("if_stall", 64'(IF_stall), 64'(sb.size() == 0));
      chk("i_read",   64'(I_read),   64'(m_iread));
      chk("i_addr",   64'(I_addr),   64'(mpc[31:2]));
      if (sb.size() == 0) begin
        chk("bubble_inst", 64'(id_inst), 64'(0));
        chk("bubble_pc",   64'(id_pc),   64'(0));
      end else if (id_ready && !redirect) begin
        ment = sb.pop_front();
        chk("head_pc",   64'(id_pc),   64'(ment[63:32]));
        chk("head_inst", 64'(id_inst), 64'(ment[31:0]));
      end
      if (!mwait) begin
        if (redirect) begin
          sb.delete();
          if (m_iread && I_stall) begin
            mwait = 1'b1;
            mpend = mtgt;
          end else begin
            mpc = mtgt;
          end
        end else if (m_iread && !I_stall) begin
          sb.push_back({mpc + 32'd4, 2'b10, mpc[31:2]});
          mpc = mpc + 32'd4;
        end
      end else begin
        if (!I_stall) begin
          mpc   = redirect ? mtgt : mpend;
          mwait = 1'b0;
        end else if (redirect) begin
          mpend = mtgt;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    redirect = 1'b0;
    I_stall = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!id_valid && k < 50) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(id_valid), 64'(1));
  endtask

  initial begin
    logic found;

    // Streaming after reset: first head is pc 0 reported as 4
    do_reset;
    id_ready = 1'b1;
    tick(1);
    chk("t1_valid", 64'(id_valid), 64'(1));
    chk("t1_pc",    64'(id_pc),    64'h4);
    chk("t1_inst",  64'(id_inst),  64'h8000_0000);
    tick(6);

    // Back-pressure fills the queue and freezes the fetch address
    do_reset;
    id_ready = 1'b0;
    tick(10);
    chk("t2_iaddr", 64'(I_addr), 64'h4);
    chk("t2_iread", 64'(I_read), 64'(0));
    id_ready = 1'b1;
    tick(8);

    // Cache miss at pc 0x20 holds the address and drains the queue
    do_reset;
    id_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (I_addr == 30'h8) found = 1'b1;
      else tick(1);
    end
    chk("t3_reach", 64'(found), 64'(1));
    I_stall = 1'b1;
    tick(5);
    chk("t3_iaddr", 64'(I_addr),   64'h8);
    chk("t3_valid", 64'(id_valid), 64'(0));
    chk("t3_inst",  64'(id_inst),  64'(0));
    I_stall = 1'b0;
    tick(4);

    // Redirect without a miss while three entries are queued; low bits ignored
    do_reset;
    id_ready = 1'b0;
    tick(3);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick(1);
    redirect = 1'b0;
    chk("t4_valid", 64'(id_valid), 64'(0));
    chk("t4_iaddr", 64'(I_addr),   64'h40);
    id_ready = 1'b1;
    wait_valid("t4_wait");
    chk("t4_pc",   64'(id_pc),   64'h104);
    chk("t4_inst", 64'(id_inst), 64'h8000_0040);
    tick(3);

    // Two redirects during one miss: newest target wins, stale data dropped
    do_reset;
    id_ready = 1'b1;
    tick(4);
    I_stall = 1'b1;
    tick(1);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick(1);
    redirect = 1'b0;
    tick(2);
    redirect = 1'b1;
    redirect_pc = 32'h300;
    tick(1);
    redirect = 1'b0;
    tick(1);
    I_stall = 1'b0;
    wait_valid("t5_wait");
    chk("t5_pc",   64'(id_pc),   64'h304);
    chk("t5_inst", 64'(id_inst), 64'h8000_00C0);
    tick(3);

    // Asynchronous reset while waiting on a redirected miss
    do_reset;
    id_ready = 1'b1;
    tick(3);
    I_stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h400;
    tick(1);
    redirect = 1'b0;
    tick(1);
    chk("t6_wait_iread", 64'(I_read), 64'(1));
`ifdef MIPS_FETCH_PERF_EN
    chk("t6_pre_fetch", 64'(perf_fetch), 64'(3));
    chk("t6_pre_flush", 64'(perf_flush), 64'(1));
`endif
    #1;
    rst = 1'b1;
    #1;
    chk("t6_iread",   64'(I_read),   64'(0));
    chk("t6_valid",   64'(id_valid), 64'(0));
    chk("t6_idpc",    64'(id_pc),    64'(0));
    chk("t6_inst",    64'(id_inst),  64'(0));
    chk("t6_ifstall", 64'(IF_stall), 64'(1));
`ifdef MIPS_FETCH_PERF_EN
    chk("t6_perf_fetch",  64'(perf_fetch),  64'(0));
    chk("t6_perf_bubble", 64'(perf_bubble), 64'(0));
    chk("t6_perf_flush",  64'(perf_flush),  64'(0));
`endif
    I_stall = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule
